// File: rtl/booth_seq_multiplier_if.sv
// booth_seq_multiplier_if: start/busy/done handshake plus operand and product bus for the Booth multiplier
interface booth_seq_multiplier_if #(parameter int WIDTH = 16);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  modport master (output start, multiplicand, multiplier, input busy, done, product);
  modport slave  (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-2 Booth signed WIDTHxWIDTH multiplier; clk, rst, bus (start/operands in, busy/done/product out)
module booth_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  booth_seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state_q, state_d;
  logic signed [WIDTH:0] a_q, a_d, m_q, m_d, addend, s;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
  always_comb begin
    addend  = {q_q[0], qm1_q} == 2'b01 ? m_q : {q_q[0], qm1_q} == 2'b10 ? -m_q : '0;
    s       = a_q + addend;
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      a_d     = '0;
      m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
      q_d     = bus.multiplier;
      qm1_d   = 1'b0;
      cnt_d   = CW'(WIDTH);
    end else if (state_q == RUN) begin
      // arithmetic shift of {S,Q,Q_m1}: sign of S refills the top of A
      a_d   = {s[WIDTH], s[WIDTH:1]};
      q_d   = {s[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        prod_d  = {a_d[WIDTH-1:0], q_d};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    bus.busy    = state_q != IDLE;
    bus.done    = state_q == DONE;
    bus.product = prod_q;
  end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: directed and exhaustive checks of the Booth multiplier against a cycle-count model
module tb_booth_seq_multiplier;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  booth_seq_multiplier_if #(.WIDTH(W)) bw ();
  booth_seq_multiplier_if #(.WIDTH(N)) bn ();
  booth_seq_multiplier #(.WIDTH(W)) dut   (.clk(clk), .rst(rst), .bus(bw.slave));
  booth_seq_multiplier #(.WIDTH(N)) dut_n (.clk(clk), .rst(rst), .bus(bn.slave));
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int rw = 0;
  int rn = 0;
  logic [2*W-1:0] pw = '0, qw = '0;
  logic [2*N-1:0] pn = '0, qn = '0;
  // model: a job occupies WIDTH+1 cycles after acceptance; its product appears in the last one
  always @(posedge clk) begin
    if (rst) begin
      rw = 0;
      pw = '0;
      rn = 0;
      pn = '0;
    end else begin
      if (rw == 0) begin
        if (bw.start) begin
          rw = W + 1;
          qw = $signed(bw.multiplicand) * $signed(bw.multiplier);
        end
      end else begin
        rw--;
        if (rw == 1) pw = qw;
      end
      if (rn == 0) begin
        if (bn.start) begin
          rn = N + 1;
          qn = $signed(bn.multiplicand) * $signed(bn.multiplier);
        end
      end else begin
        rn--;
        if (rn == 1) pn = qn;
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy16", 64'(bw.busy), 64'(rw > 0));
      chk("done16", 64'(bw.done), 64'(rw == 1));
      chk("product16", 64'(bw.product), 64'(pw));
      chk("busy4", 64'(bn.busy), 64'(rn > 0));
      chk("done4", 64'(bn.done), 64'(rn == 1));
      chk("product4", 64'(bn.product), 64'(pn));
    end
  end
  task automatic run16(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp, input string nm);
    int n;
    @(negedge clk);
    bw.start = 1'b1;
    bw.multiplicand = a;
    bw.multiplier = b;
    @(negedge clk);
    bw.start = 1'b0;
    bw.multiplicand = 16'($urandom);
    bw.multiplier = 16'($urandom);
    n = 1;
    while (bw.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(W + 1));
    chk(nm, 64'(bw.product), 64'(exp));
    @(negedge clk);
    chk({nm, " idle"}, 64'(bw.busy), 64'(0));
  endtask
  task automatic run4(input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    logic [2*N-1:0] exp;
    exp = $signed(a) * $signed(b);
    @(negedge clk);
    bn.start = 1'b1;
    bn.multiplicand = a;
    bn.multiplier = b;
    @(negedge clk);
    bn.start = 1'b0;
    n = 1;
    while (bn.done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("w4 latency", 64'(n), 64'(N + 1));
    chk("w4 product", 64'(bn.product), 64'(exp));
  endtask
  initial begin
    int n;
    int d;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] e;
    bw.start = 1'b0;
    bw.multiplicand = '0;
    bw.multiplier = '0;
    bn.start = 1'b0;
    bn.multiplicand = '0;
    bn.multiplier = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy", 64'(bw.busy), 64'(0));
    chk("reset done", 64'(bw.done), 64'(0));
    chk("reset product", 64'(bw.product), 64'(0));
    rst = 1'b0;
    run16(16'd3, 16'd5, 32'h0000000F, "3x5");
    run16(16'hFFF9, 16'd6, 32'hFFFFFFD6, "-7x6");
    run16(16'd6, 16'hFFF9, 32'hFFFFFFD6, "6x-7");
    run16(16'h8000, 16'h8000, 32'h40000000, "min x min");
    run16(16'h8000, 16'h7FFF, 32'hC0008000, "min x max");
    run16(16'd0, 16'h1234, 32'h0, "0x1234");
    run16(16'h1234, 16'd0, 32'h0, "1234x0");
    @(negedge clk);
    bw.start = 1'b1;
    bw.multiplicand = 16'd100;
    bw.multiplier = 16'd7;
    @(negedge clk);
    n = 1;
    while (bw.done !== 1'b1 && n < 40) begin
      if (n == 5) begin
        bw.start = 1'b1;
        bw.multiplicand = 16'd9;
        bw.multiplier = 16'd9;
      end else bw.start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("ignored start latency", 64'(n), 64'(W + 1));
    chk("ignored start product", 64'(bw.product), 64'h2BC);
    @(negedge clk);
    bw.start = 1'b1;
    bw.multiplicand = 16'd2;
    bw.multiplier = 16'd3;
    @(negedge clk);
    n = 1;
    d = 0;
    while (n < 60) begin
      if (bw.done === 1'b1) begin
        d++;
        if (d == 2) break;
      end
      @(negedge clk);
      n++;
    end
    bw.start = 1'b0;
    chk("held start second done", 64'(n), 64'(35));
    chk("held start product", 64'(bw.product), 64'h6);
    @(negedge clk);
    bw.start = 1'b1;
    bw.multiplicand = 16'd100;
    bw.multiplier = 16'd100;
    @(negedge clk);
    bw.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset busy", 64'(bw.busy), 64'(0));
    chk("mid reset done", 64'(bw.done), 64'(0));
    chk("mid reset product", 64'(bw.product), 64'(0));
    run16(16'hFFFD, 16'hFFFD, 32'h00000009, "after reset -3x-3");
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      e = $signed(a) * $signed(b);
      run16(a, b, e, "random");
    end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run4(4'(i), 4'(j));
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
